// File: rtl/data_pipe_interconnect_m2s_rr.sv
// Many-to-one valid/ready merge: a round-robin arbiter feeds one registered
// output stage, and each beat is tagged with the index of its source.
module data_pipe_interconnect_m2s_rr #(
  parameter int NUM   = 8,
  parameter int DSIZE = 8,
  parameter int NSIZE = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic [NUM-1:0]       s_valid,
  input  logic [NUM*DSIZE-1:0] s_data,
  output logic [NUM-1:0]       s_ready,
  output logic                 m_valid,
  output logic [DSIZE-1:0]     m_data,
  output logic [NSIZE-1:0]     m_sid,
  input  logic                 m_ready
);

  logic             r_mValid;
  logic [DSIZE-1:0] r_mData;
  logic [NSIZE-1:0] r_mSid;
  logic [NSIZE-1:0] r_lastGrant;

  logic             w_loadEn;
  logic             w_anyValid;
  logic [NSIZE-1:0] w_grant;
  logic [DSIZE-1:0] w_grantData;
  logic             w_xfer;

  // m_ready reaches s_ready combinationally; the output stage has no skid buffer.
  assign w_loadEn = ~rst & clk_en & (~r_mValid | m_ready);
  assign w_xfer   = w_loadEn & w_anyValid;

  generate
    if (NUM == 1) begin : g_single
      assign w_anyValid  = s_valid[0];
      assign w_grant     = '0;
      assign w_grantData = s_data[DSIZE-1:0];
      assign s_ready     = w_loadEn;

      logic w_unusedGrant;
      assign w_unusedGrant = ^r_lastGrant;
    end else begin : g_multi
      // Scan from last_grant+1 upward, wrapping explicitly so odd NUM never aliases.
      always_comb begin
        int               idx;
        logic [NSIZE-1:0] cand;
        idx        = 0;
        cand       = '0;
        w_anyValid = 1'b0;
        w_grant    = '0;
        for (int off = 1; off <= NUM; off++) begin
          idx = int'(r_lastGrant) + off;
          if (idx >= NUM) begin
            idx = idx - NUM;
          end
          cand = NSIZE'(idx);
          if (!w_anyValid && s_valid[cand]) begin
            w_anyValid = 1'b1;
            w_grant    = cand;
          end
        end
      end

      always_comb begin
        w_grantData = '0;
        for (int k = 0; k < NUM; k++) begin
          if (NSIZE'(k) == w_grant) begin
            w_grantData = s_data[k*DSIZE +: DSIZE];
          end
        end
      end

      always_comb begin
        s_ready = '0;
        if (w_xfer) begin
          s_ready[w_grant] = 1'b1;
        end
      end
    end
  endgenerate

  // A new beat replaces a draining one in the same cycle, so there is no bubble.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_mValid    <= 1'b0;
      r_mData     <= '0;
      r_mSid      <= '0;
      r_lastGrant <= NSIZE'(NUM - 1);
    end else if (clk_en) begin
      if (w_xfer) begin
        r_mValid    <= 1'b1;
        r_mData     <= w_grantData;
        r_mSid      <= w_grant;
        r_lastGrant <= w_grant;
      end else if (m_ready) begin
        r_mValid <= 1'b0;
      end
    end
  end

  assign m_valid = r_mValid;
  assign m_data  = r_mData;
  assign m_sid   = r_mSid;

endmodule

// File: tb/tb_data_pipe_interconnect_m2s_rr.sv
// Drives an 8-source and a 3-source merge from the same stimulus and checks both
// against a cycle-level model built from the arbitration and handshake rules.
module tb_data_pipe_interconnect_m2s_rr;

  logic        clock = 1'b0;
  logic        rst;
  logic        clkEn;
  logic        mReady;
  logic [7:0]  sValid;
  logic [63:0] sData;

  logic [7:0]  sReady8;
  logic        mValid8;
  logic [7:0]  mData8;
  logic [2:0]  mSid8;

  logic [2:0]  sReady3;
  logic        mValid3;
  logic [7:0]  mData3;
  logic [1:0]  mSid3;

  int testCount = 0;
  int failCount = 0;

  int expValid[2];
  int expData[2];
  int expSid[2];
  int lastGrant[2];

  always #5 clock = ~clock;

  data_pipe_interconnect_m2s_rr #(.NUM(8), .DSIZE(8)) u8 (
    .clock(clock), .rst(rst), .clk_en(clkEn),
    .s_valid(sValid), .s_data(sData), .s_ready(sReady8),
    .m_valid(mValid8), .m_data(mData8), .m_sid(mSid8), .m_ready(mReady)
  );

  data_pipe_interconnect_m2s_rr #(.NUM(3), .DSIZE(8)) u3 (
    .clock(clock), .rst(rst), .clk_en(clkEn),
    .s_valid(sValid[2:0]), .s_data(sData[23:0]), .s_ready(sReady3),
    .m_valid(mValid3), .m_data(mData3), .m_sid(mSid3), .m_ready(mReady)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int numOf(input int i);
    return (i == 0) ? 8 : 3;
  endfunction

  function automatic int modelGrant(input int num, input logic [7:0] v, input int lg);
    for (int off = 1; off <= num; off++) begin
      int k;
      k = (lg + off) % num;
      if (((v >> k) & 8'h01) != 8'h00) return k;
    end
    return -1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      expValid[i]  = 0;
      expData[i]   = 0;
      expSid[i]    = 0;
      lastGrant[i] = numOf(i) - 1;
    end
  endtask

  // One clock: drive after the edge, check at the falling edge, then advance the model.
  task automatic applyStimulus(input logic r, input logic en, input logic mr,
                               input logic [7:0] v, input logic [63:0] d);
    @(posedge clock);
    #1;
    rst = r; clkEn = en; mReady = mr; sValid = v; sData = d;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      int num;
      int g;
      bit loadEn;
      logic [31:0] expReady;
      logic [31:0] obsReady, obsValid, obsData, obsSid;
      num = numOf(i);
      g = modelGrant(num, v, lastGrant[i]);
      loadEn = !r && en && (expValid[i] == 0 || mr);
      expReady = (loadEn && g >= 0) ? (32'd1 << g) : 32'd0;
      obsReady = (i == 0) ? {24'd0, sReady8} : {29'd0, sReady3};
      obsValid = (i == 0) ? {31'd0, mValid8} : {31'd0, mValid3};
      obsData  = (i == 0) ? {24'd0, mData8}  : {24'd0, mData3};
      obsSid   = (i == 0) ? {29'd0, mSid8}   : {30'd0, mSid3};
      checkOutput($sformatf("n%0d s_ready", num), obsReady, expReady);
      checkOutput($sformatf("n%0d m_valid", num), obsValid, expValid[i]);
      checkOutput($sformatf("n%0d m_data", num), obsData, expData[i]);
      checkOutput($sformatf("n%0d m_sid", num), obsSid, expSid[i]);
      if (r) begin
        expValid[i] = 0; expData[i] = 0; expSid[i] = 0; lastGrant[i] = num - 1;
      end else if (en) begin
        if (loadEn && g >= 0) begin
          expValid[i]  = 1;
          expData[i]   = int'((d >> (8 * g)) & 64'hFF);
          expSid[i]    = g;
          lastGrant[i] = g;
        end else if (mr) begin
          expValid[i] = 0;
        end
      end
    end
  endtask

  function automatic logic [63:0] rampData();
    logic [63:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) d[k*8 +: 8] = 8'hA0 + 8'(k);
    return d;
  endfunction

  initial begin
    logic [63:0] ramp;
    logic [63:0] rnd;
    ramp = rampData();
    rst = 1'b1; clkEn = 1'b1; mReady = 1'b1; sValid = 8'h00; sData = '0;
    modelReset();
    repeat (2) @(posedge clock);

    // Reset held with every source valid
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, ramp);
      checkOutput("reset sReady8", {24'd0, sReady8}, 32'h0);
      checkOutput("reset mValid8", {31'd0, mValid8}, 32'h0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, ramp);
    checkOutput("release sReady8", {24'd0, sReady8}, 32'h01);
    checkOutput("release sReady3", {29'd0, sReady3}, 32'h1);

    // Fair rotation at full rate
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, ramp);
      if (c == 0) begin
        checkOutput("first beat mValid8", {31'd0, mValid8}, 32'h1);
        checkOutput("first beat mSid8", {29'd0, mSid8}, 32'h0);
        checkOutput("first beat mData8", {24'd0, mData8}, 32'hA0);
      end
    end

    // Sparse wrap, then a lone high-index source
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h04, ramp);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b1, 1'b1, 8'h03, ramp);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b1, 1'b1, 8'h08, ramp);

    // Backpressure with a held 0x5C beat
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, {8{8'h5C}});
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF, ramp);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, ramp);

    // Global stall mid-stream
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, ramp);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, ramp);

    // Toggling ready, then reset mid-stream
    for (int c = 0; c < 8; c++) applyStimulus(1'b0, 1'b1, c[0] == 1'b0, 8'hFF, ramp);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, ramp);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, ramp);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      logic [7:0] v;
      case ($urandom_range(0, 3))
        0:       v = 8'($urandom);
        1:       v = 8'($urandom) & 8'($urandom);
        2:       v = 8'h01 << $urandom_range(0, 7);
        default: v = 8'hFF;
      endcase
      rnd = {$urandom, $urandom};
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 90,
                    $urandom_range(0, 99) < 70, v, rnd);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/data_pipe_interconnect_m2s_rr.md
Name: data_pipe_interconnect_M2S_rr

Overview:
- Many-to-one merge for the data_inf valid/ready stream. It is the return-direction counterpart of the one-slave-to-many-master address demux.
- NUM upstream sources compete for one downstream master port. A round-robin arbiter picks one source per cycle.
- The granted beat goes into a single registered output stage, tagged with its source index, so downstream logic can route responses back.
- Full throughput: one beat per cycle. Latency: one cycle.

Parameters:
- NUM, 8, number of source ports (≥1).
- DSIZE, 8, data width per beat.
- NSIZE, (NUM>1 ? $clog2(NUM) : 1), width of the source-index tag.

Ports:
- clock  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  global stall; 0 freezes all state.
- s_valid  in  NUM  per-source valid.
- s_data  in  NUM*DSIZE  per-source data; source k occupies bits [k*DSIZE +: DSIZE].
- s_ready  out  NUM  per-source ready; at most one bit is high in any cycle.
- m_valid  out  1  output beat valid (registered).
- m_data  out  DSIZE  output beat data (registered).
- m_sid  out  NSIZE  index of the source that produced the current m_data (registered).
- m_ready  in  1  downstream ready.

Behaviour:
- Reset is decided: one clock; reset is synchronous and active-high.
- Reset values: m_valid=0, m_data=0, m_sid=0, last_grant=NUM-1. Source 0 therefore has highest priority on the first arbitration.
- rst overrides clk_en.
- load_en = clk_en & (~m_valid | m_ready).
  - This is a combinational path m_ready→s_ready, and it is intentional.
  - Skid-free, so downstream must not make m_ready depend on s_ready.
- Arbitration is combinational:
  - Scan sources last_grant+1, last_grant+2, … modulo NUM.
  - The first source with s_valid=1 is the grant g.
  - No valid source means no grant.
- s_ready[k] = load_en & (k==g) & any_valid. Transfer on source k ⇔ s_valid[k] & s_ready[k].
- On a transfer from g, at the clock edge:
  - m_valid←1, m_data←s_data[g], m_sid←g.
  - last_grant←g.
- Drain: if m_valid & m_ready & clk_en and there is no new transfer that cycle, then m_valid←0. m_data and m_sid hold their last values.
- Simultaneous drain and load in the same cycle:
  - The new beat replaces the old one with no bubble.
  - m_valid stays 1.
  - Sustained rate is 1 beat/cycle.
- Backpressure: while m_valid=1 & m_ready=0:
  - All s_ready are 0.
  - m_data and m_sid are stable.
  - last_grant is unchanged.
- last_grant changes only on an actual transfer. Idle cycles do not advance the pointer.
- Wrap-around:
  - After a grant to NUM-1, the scan restarts at 0.
  - With a single active source, that source is granted every cycle.
- Source-side rule: a source may drop s_valid without a handshake. The arbiter re-evaluates every cycle; no grant is latched across cycles.
- clk_en=0:
  - All s_ready are 0.
  - No register updates.
  - m_valid/m_data/m_sid hold.
  - Downstream may still see m_valid=1, but a beat is not consumed while clk_en=0.
- Reset mid-operation:
  - The pending output beat is discarded (m_valid→0 on the next edge).
  - Arbitration restarts at source 0.
  - While rst=1, s_ready=0.
- NUM=1: the arbiter degenerates. s_ready[0] = load_en, m_sid is constant 0, and the same output register is used.
- Width rules:
  - m_sid is zero-extended to NSIZE.
  - Modulo-NUM increment handles non-power-of-2 NUM explicitly, with no NSIZE overflow.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with all s_valid=1 → s_ready=0 and m_valid=0 throughout. On the first cycle after release, s_ready=8'h01; the next cycle shows m_valid=1, m_sid=0.
2. Fair rotation: NUM=4, all s_valid=1, s_data[k]=8'hA0+k, m_ready=1 constant → m_sid sequence 0,1,2,3,0,1…, m_data A0,A1,A2,A3,A0…, m_valid high on every cycle after the first.
3. Sparse wrap: last_grant=2, only sources 0 and 1 valid → grant 0 next, then 1, then 0. Source 3 valid alone → granted every cycle.
4. Backpressure: m_ready=0 for 5 cycles while m_valid=1, m_data=8'h5C → m_data, m_sid and m_valid stable and s_ready=0 for all 5 cycles. When m_ready rises, the next source in rotation transfers in that same cycle.
5. clk_en=0 for 4 cycles mid-stream → no transfers, outputs frozen, rotation resumes at the correct next index when clk_en returns.
6. NUM=3 (non-power-of-2), all sources valid, m_ready toggling 1,0,1,0 → m_sid 0,1,2,0 with each beat held for its stall cycle, never index 3. Assert rst mid-stream → m_valid=0 next cycle and the grant restarts at 0.
